rr_arbiter: RTL and testbench
=============================

// Module: rr_arbiter
// PURPOSE
//   N-requester arbiter that grants one shared resource to one requester at a time.
//   Supports fixed-priority or round-robin selection, chosen per arbitration by an input.
//   An optional hold limit (MAX_HOLD) forces the current owner to release the resource.
//   Back-to-back handover is supported: a new owner can be granted with no idle cycle.
//   Sits between the requesting masters and the shared resource, like the 3-way FSM arbiter.
// PARAMETERS
//   N         4                Number of requesters (>= 1).
//   MAX_HOLD  16               Max consecutive grant cycles per ownership; 0 = unlimited.
//   IDW       $clog2(N)>1?..:1 Width of gnt_id, = max($clog2(N),1).
// PORTS
//   clk        in   1    System clock; all state changes on posedge.
//   rst        in   1    Synchronous reset, active-high.
//   r          in   N    Request vector; r[i]=1 means requester i wants or keeps the resource.
//   mode       in   1    0 = fixed priority (index 0 highest); 1 = round-robin.
//   g          out  N    Registered one-hot grant; all-zero when idle.
//   gnt_valid  out  1    Registered; equals |g.
//   gnt_id     out  IDW  Registered index of the owner; holds its last value when idle.
// BEHAVIOUR
//   Reset (rst=1 at posedge)
//     - g=0, gnt_valid=0, gnt_id=0, state=IDLE, hold_cnt=0, rr_ptr=0.
//     - Applies mid-grant too: the grant drops on the first edge that samples rst=1.
//   Latency
//     - A request sampled at edge k produces its grant at edge k (registered output).
//     - The grant is visible for the cycle after k; there is no combinational path r->g.
//   Winner selection over an eligible vector e
//     - mode=0: the lowest set index of e wins.
//     - mode=1: the first set bit of e, searching upward from rr_ptr with wrap N-1 -> 0.
//     - mode is sampled only at arbitration edges; a change while a grant is held has
//       no effect on that grant.
//   State machine: two states, IDLE and BUSY. owner is the registered gnt_id.
//     IDLE
//       - If e = r is nonzero: go to BUSY; owner = winner; hold_cnt = 0.
//       - Otherwise stay in IDLE.
//     BUSY, on each edge
//       - release = !r[owner] | (MAX_HOLD != 0 && hold_cnt == MAX_HOLD-1).
//       - No release: stay in BUSY; hold_cnt = hold_cnt + 1, saturating at all-ones.
//       - Release: form e = r with bit owner cleared.
//           - e nonzero: stay in BUSY with owner = winner(e) and hold_cnt = 0 (zero-gap handover).
//           - e zero: go to IDLE; g = 0.
//       - The owner bit is always masked on release, so a timed-out owner cannot re-win
//         on the same edge, in either mode.
//   Round-robin pointer
//     - On every edge that grants a new owner w (from IDLE or on handover): rr_ptr = (w+1) mod N.
//     - This update is done in both modes, so switching to mode=1 continues fairly.
//   Invariants
//     - At most one bit of g is set.
//     - g[i] is only set if r[i] was 1 at the granting edge.
//   Widths
//     - hold_cnt is max($clog2(MAX_HOLD),1) bits.
//     - rr_ptr is IDW bits; the wrap is explicit, so N need not be a power of 2.
//   N=1
//     - g = r delayed one cycle; with MAX_HOLD active there is a forced 1-cycle idle gap.
// TESTING (N=4, MAX_HOLD=4 unless stated)
//   1. rst=1 for 3 cycles with r=4'b1111 -> g=0 throughout; first edge after rst=0 -> g=4'b0001.
//   2. mode=0, r=4'b1010 -> g=4'b0010 while r[1]=1; clear r[1] -> next edge g=4'b1000 (no gap).
//   3. mode=1, r=4'b1111 constant -> g=0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 again.
//   4. mode=0, r=4'b0011 constant -> g=0001 x4, 0010 x4, 0001 x4 (timeout masks only the owner).
//   5. r=4'b0001 constant -> g=0001 x4, then g=0 for 1 cycle (IDLE), then 0001 x4 again.
//   6. Mid-grant: owner=2, assert rst for 1 cycle -> g=0; then r=4'b1100, mode=1 -> g=4'b0100 (rr_ptr reset to 0).

Source files
------------

// File: rtl/rr_arbiter.sv
// N-requester arbiter for one shared resource: fixed-priority or round-robin winner
// selection, registered one-hot grant, optional hold limit and zero-gap handover.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   r,
    input  logic           mode,
    output logic [N-1:0]   g,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           dbg_state
);
    // Handshake: a requester raises r[i] and keeps it high for as long as it wants the
    // resource; it owns the resource in every cycle where g[i]=1, and dropping r[i] is
    // its release, taking effect on the next edge (another owner may be granted there).

    localparam int HW = ($clog2(MAX_HOLD) > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(N - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   g_q, g_d;
    logic           gnt_valid_q, gnt_valid_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    logic [N-1:0]   elig;
    logic           grant_new;
    logic           release_own;
    logic [IDW-1:0] winner;

    // First set bit of e searching upward from start, wrapping N-1 -> 0.
    function automatic logic [IDW-1:0] pick(input logic [N-1:0] e, input logic [IDW-1:0] start);
        logic [IDW-1:0] win;
        logic           found;
        int             idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(start) + k;
            if (idx >= N) idx = idx - N;
            if (!found && e[idx]) begin
                win   = IDW'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        gnt_id_d    = gnt_id_q;
        hold_cnt_d  = hold_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        elig        = r;
        grant_new   = 1'b0;
        release_own = 1'b0;
        winner      = '0;

        case (state_q)
            IDLE: begin
                if (|r) grant_new = 1'b1;
            end
            BUSY: begin
                release_own = !r[gnt_id_q] || ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST));
                if (!release_own) begin
                    if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + 1'b1;
                end else begin
                    // The outgoing owner is masked so a timed-out owner cannot re-win here.
                    elig = r & ~(N'(1) << gnt_id_q);
                    if (|elig) begin
                        grant_new = 1'b1;
                    end else begin
                        state_d = IDLE;
                        g_d     = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_new) begin
            // Fixed priority is a round-robin search that always starts at index 0.
            winner     = pick(elig, mode ? rr_ptr_q : '0);
            state_d    = BUSY;
            gnt_id_d   = winner;
            g_d        = N'(1) << winner;
            hold_cnt_d = '0;
            rr_ptr_d   = (winner == LAST_ID) ? '0 : winner + 1'b1;
        end

        gnt_valid_d = |g_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            g_q         <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            hold_cnt_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            hold_cnt_q  <= hold_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign g         = g_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter (N=4, MAX_HOLD=4): directed scenarios with fixed expectations,
// then random traffic, all scored against an integer-level ownership model.
module tb_rr_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int IDW      = 2;
  localparam int W        = 1 + IDW + N;

  logic           clk;
  logic           rst;
  logic [N-1:0]   r;
  logic           mode;
  logic [N-1:0]   g;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           dbg_state;

  int n_checks;
  int n_errors;

  logic [W-1:0] exp_q[$];

  // model: who owns the resource, for how many cycles so far, where round-robin resumes
  bit m_busy;
  int m_owner;
  int m_tenure;
  int m_ptr;
  int m_last_id;

  rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .r         (r),
    .mode      (mode),
    .g         (g),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int choose(input logic [N-1:0] e, input logic md);
    int start;
    start = md ? m_ptr : 0;
    for (int k = 0; k < N; k++) begin
      if (e[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_take(input logic [N-1:0] e, input logic md);
    int w;
    w = choose(e, md);
    m_busy    = 1'b1;
    m_owner   = w;
    m_last_id = w;
    m_tenure  = 1;
    m_ptr     = (w + 1) % N;
  endtask

  task automatic model_step(input logic [N-1:0] rv, input logic md, input logic rs);
    logic [N-1:0] others;
    if (rs) begin
      m_busy    = 1'b0;
      m_last_id = 0;
      m_tenure  = 0;
      m_ptr     = 0;
    end else if (!m_busy) begin
      if (rv != 0) model_take(rv, md);
    end else if (rv[m_owner] && m_tenure < MAX_HOLD) begin
      m_tenure++;
    end else begin
      others = rv;
      others[m_owner] = 1'b0;
      if (others != 0) model_take(others, md);
      else m_busy = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic [N-1:0] gv;
    gv = '0;
    if (m_busy) gv[m_owner] = 1'b1;
    return {m_busy, IDW'(m_last_id), gv};
  endfunction

  // driver: apply inputs at negedge, model the edge, score outputs at the next negedge
  task automatic cycle(input logic [N-1:0] rv, input logic md, input logic rs);
    logic [W-1:0] e;
    r    = rv;
    mode = md;
    rst  = rs;
    @(posedge clk);
    model_step(rv, md, rs);
    exp_q.push_back(model_out());
    @(negedge clk);
    e = exp_q.pop_front();
    check("g", 32'(g), 32'(e[N-1:0]));
    check("gnt_valid", 32'(gnt_valid), 32'(e[W-1]));
    check("gnt_id", 32'(gnt_id), 32'(e[N +: IDW]));
  endtask

  initial begin
    logic [N-1:0] rnd_r;
    logic [N-1:0] exp_g;
    n_checks = 0;
    n_errors = 0;
    m_busy = 1'b0; m_owner = 0; m_tenure = 0; m_ptr = 0; m_last_id = 0;
    r = '0; mode = 1'b0; rst = 1'b1;
    @(negedge clk);

    // reset held with all requesting, then first grant goes to index 0
    for (int c = 0; c < 3; c++) begin
      cycle(4'b1111, 1'b0, 1'b1);
      check("rst_g", 32'(g), 32'h0);
    end
    check("rst_id", 32'(gnt_id), 32'h0);
    cycle(4'b1111, 1'b0, 1'b0);
    check("first_g", 32'(g), 32'b0001);

    // fixed priority, zero-gap handover on release
    cycle(4'b0000, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      cycle(4'b1010, 1'b0, 1'b0);
      check("fp_g", 32'(g), 32'b0010);
    end
    cycle(4'b1000, 1'b0, 1'b0);
    check("handover_g", 32'(g), 32'b1000);

    // round-robin rotation with timeout after MAX_HOLD cycles
    cycle(4'b0000, 1'b0, 1'b1);
    for (int c = 0; c < 17; c++) begin
      cycle(4'b1111, 1'b1, 1'b0);
      exp_g = 4'b0001 << ((c / MAX_HOLD) % N);
      check("rr_g", 32'(g), 32'(exp_g));
    end

    // fixed priority timeout masks only the owner
    cycle(4'b0000, 1'b0, 1'b1);
    for (int c = 0; c < 12; c++) begin
      cycle(4'b0011, 1'b0, 1'b0);
      exp_g = 4'b0001 << ((c / MAX_HOLD) % 2);
      check("fp_timeout_g", 32'(g), 32'(exp_g));
    end

    // single requester: forced idle cycle after timeout
    cycle(4'b0000, 1'b0, 1'b1);
    for (int c = 0; c < 9; c++) begin
      cycle(4'b0001, 1'b1, 1'b0);
      exp_g = (c == MAX_HOLD) ? 4'b0000 : 4'b0001;
      check("single_g", 32'(g), 32'(exp_g));
    end

    // mid-grant reset clears the round-robin pointer
    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b0100, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 1'b0);
    check("owner2_id", 32'(gnt_id), 32'd2);
    cycle(4'b0100, 1'b1, 1'b1);
    check("midrst_g", 32'(g), 32'h0);
    cycle(4'b1100, 1'b1, 1'b0);
    check("ptr_reset_g", 32'(g), 32'b0100);

    // random traffic: requests persist for a while, mode toggles freely, rare resets
    rnd_r = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) rnd_r = N'($urandom_range(0, (1 << N) - 1));
      cycle(rnd_r, 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
